move_scheduler: RTL and testbench

//  Sequences the shared combinational collision_detector between two players. Each player

---
 rtl/game_defs.sv | 27 ++
 rtl/move_cooldown.sv | 42 ++++
 rtl/move_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_move_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_defs.sv
// Shared definitions for the game datapath: move codes, coordinate and map widths,
// the scheduler state type and a helper that folds unused move codes onto "none".
package game_defs;

    localparam int unsigned COORD_W = 5;
    localparam int unsigned MAP_W   = 2;

    localparam logic [2:0] MOVE_NONE  = 3'b000;
    localparam logic [2:0] MOVE_UP    = 3'b001;
    localparam logic [2:0] MOVE_DOWN  = 3'b010;
    localparam logic [2:0] MOVE_LEFT  = 3'b011;
    localparam logic [2:0] MOVE_RIGHT = 3'b100;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StCommit
    } sched_state_e;

    // Codes 101-111 carry no move and behave exactly like MOVE_NONE.
    function automatic logic [2:0] move_sanitize(input logic [2:0] code);
        return (code > MOVE_RIGHT) ? MOVE_NONE : code;
    endfunction

endpackage

// File: rtl/move_cooldown.sv
// Per-player move cooldown counter.
// Ports:
//   clk    - system clock
//   resetn - synchronous active-low reset, clears the counter
//   clear  - synchronous clear (game restart), clears the counter
//   load   - load COOLDOWN (takes priority over counting down)
//   zero   - high while the counter is zero, i.e. the player may be granted again
module move_cooldown #(
    parameter int unsigned COOLDOWN = 12500000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic load,
    output logic zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(COOLDOWN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/move_scheduler.sv
// Round-robin scheduler sharing one external combinational collision detector between
// two players. Owns both position registers, per-player cooldowns and the overlap check.
// Ports:
//   clk, resetn           - clock, synchronous active-low reset
//   restart               - level restart: reload start positions, abort any in-flight op
//   map_i                 - current map select (captured at grant)
//   req_i                 - per-player move request, held until ack
//   move0_i / move1_i     - per-player move codes
//   ack_o                 - one-cycle pulse when that player's move is committed or rejected
//   p0_x/p0_y, p1_x/p1_y  - player positions
//   cd_x/cd_y/cd_move/cd_map - detector inputs
//   cd_new_x/cd_new_y     - detector result
//   busy_o                - high while an op is in LOOKUP or COMMIT
module move_scheduler
    import game_defs::*;
#(
    parameter int unsigned         COOLDOWN = 12500000,
    parameter int unsigned         CNT_W    = 24,
    parameter logic [COORD_W-1:0]  P0_X     = 5'd1,
    parameter logic [COORD_W-1:0]  P0_Y     = 5'd1,
    parameter logic [COORD_W-1:0]  P1_X     = 5'd30,
    parameter logic [COORD_W-1:0]  P1_Y     = 5'd30
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               restart,
    input  logic [MAP_W-1:0]   map_i,
    input  logic [1:0]         req_i,
    input  logic [2:0]         move0_i,
    input  logic [2:0]         move1_i,
    output logic [1:0]         ack_o,
    output logic [COORD_W-1:0] p0_x,
    output logic [COORD_W-1:0] p0_y,
    output logic [COORD_W-1:0] p1_x,
    output logic [COORD_W-1:0] p1_y,
    output logic [COORD_W-1:0] cd_x,
    output logic [COORD_W-1:0] cd_y,
    output logic [2:0]         cd_move,
    output logic [MAP_W-1:0]   cd_map,
    input  logic [COORD_W-1:0] cd_new_x,
    input  logic [COORD_W-1:0] cd_new_y,
    output logic               busy_o
);

    sched_state_e     state_q, state_d;
    logic             win_q, win_d;
    logic             last_q, last_d;   // player granted most recently
    logic [2:0]       mv_q, mv_d;
    logic [MAP_W-1:0] map_q, map_d;
    coord_t           cand_x_q, cand_x_d;
    coord_t           cand_y_q, cand_y_d;
    coord_t           pos_x_q [2];
    coord_t           pos_y_q [2];
    coord_t           pos_x_d [2];
    coord_t           pos_y_d [2];

    logic [1:0] cool_zero;
    logic [1:0] cool_load;
    logic [1:0] elig;
    logic [2:0] mv0, mv1;
    logic       grant;

    for (genvar g = 0; g < 2; g++) begin : gen_cool
        move_cooldown #(
            .COOLDOWN (COOLDOWN),
            .CNT_W    (CNT_W)
        ) u_cool (
            .clk    (clk),
            .resetn (resetn),
            .clear  (restart),
            .load   (cool_load[g]),
            .zero   (cool_zero[g])
        );
    end

    assign mv0     = move_sanitize(move0_i);
    assign mv1     = move_sanitize(move1_i);
    assign elig[0] = req_i[0] & (mv0 != MOVE_NONE) & cool_zero[0];
    assign elig[1] = req_i[1] & (mv1 != MOVE_NONE) & cool_zero[1];
    // On a tie the player not granted last wins; otherwise the single eligible one.
    assign grant   = (elig == 2'b11) ? ~last_q : elig[1];

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        mv_d      = mv_q;
        map_d     = map_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        cool_load = '0;
        ack_o     = '0;

        unique case (state_q)
            StIdle: begin
                if (elig != 2'b00) begin
                    win_d   = grant;
                    last_d  = grant;
                    mv_d    = grant ? mv1 : mv0;
                    map_d   = map_i;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                cand_x_d = cd_new_x;
                cand_y_d = cd_new_y;
                state_d  = StCommit;
            end
            StCommit: begin
                ack_o[win_q]     = 1'b1;
                cool_load[win_q] = 1'b1;
                // Moving onto the other player is rejected but still acknowledged.
                if (!((cand_x_q == pos_x_q[~win_q]) && (cand_y_q == pos_y_q[~win_q]))) begin
                    pos_x_d[win_q] = cand_x_q;
                    pos_y_d[win_q] = cand_y_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // An op aborted by reset or restart produces no ack.
        if (!resetn || restart) begin
            ack_o = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            mv_q       <= MOVE_NONE;
            map_q      <= '0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            pos_x_q[0] <= P0_X;
            pos_y_q[0] <= P0_Y;
            pos_x_q[1] <= P1_X;
            pos_y_q[1] <= P1_Y;
        end else if (restart) begin
            // Round-robin pointer survives a restart.
            state_q    <= StIdle;
            win_q      <= 1'b0;
            mv_q       <= MOVE_NONE;
            pos_x_q[0] <= P0_X;
            pos_y_q[0] <= P0_Y;
            pos_x_q[1] <= P1_X;
            pos_y_q[1] <= P1_Y;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            mv_q     <= mv_d;
            map_q    <= map_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
        end
    end

    always_comb begin
        if (state_q == StLookup) begin
            cd_x    = pos_x_q[win_q];
            cd_y    = pos_y_q[win_q];
            cd_move = mv_q;
            cd_map  = map_q;
        end else begin
            cd_x    = pos_x_q[0];
            cd_y    = pos_y_q[0];
            cd_move = MOVE_NONE;
            cd_map  = map_i;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign p0_x   = pos_x_q[0];
    assign p0_y   = pos_y_q[0];
    assign p1_x   = pos_x_q[1];
    assign p1_y   = pos_y_q[1];

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a transaction-level model of the scheduler.
module tb_move_scheduler;

    localparam int COOL = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] map_i = 2'd0;
    logic [1:0] req_i = 2'd0;
    logic [2:0] move0_i = 3'd0;
    logic [2:0] move1_i = 3'd0;
    logic [1:0] ack_o;
    logic [4:0] p0_x, p0_y, p1_x, p1_y, cd_x, cd_y, cd_new_x, cd_new_y;
    logic [2:0] cd_move;
    logic [1:0] cd_map;
    logic       busy_o;

    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;
    logic [1:0] last_ack = 2'b00;

    always #5 clk = ~clk;

    move_scheduler #(
        .COOLDOWN (COOL),
        .CNT_W    (3),
        .P0_X     (5'd1),
        .P0_Y     (5'd1),
        .P1_X     (5'd30),
        .P1_Y     (5'd30)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .restart  (restart),
        .map_i    (map_i),
        .req_i    (req_i),
        .move0_i  (move0_i),
        .move1_i  (move1_i),
        .ack_o    (ack_o),
        .p0_x     (p0_x),
        .p0_y     (p0_y),
        .p1_x     (p1_x),
        .p1_y     (p1_y),
        .cd_x     (cd_x),
        .cd_y     (cd_y),
        .cd_move  (cd_move),
        .cd_map   (cd_map),
        .cd_new_x (cd_new_x),
        .cd_new_y (cd_new_y),
        .busy_o   (busy_o)
    );

    // Open-field detector: one step, clamped to 0..31.
    function automatic int step_x(int x, int c);
        if (c == 3) return (x > 0) ? x - 1 : 0;
        if (c == 4) return (x < 31) ? x + 1 : 31;
        return x;
    endfunction

    function automatic int step_y(int y, int c);
        if (c == 1) return (y > 0) ? y - 1 : 0;
        if (c == 2) return (y < 31) ? y + 1 : 31;
        return y;
    endfunction

    always_comb begin
        cd_new_x = 5'(step_x(int'(cd_x), int'(cd_move)));
        cd_new_y = 5'(step_y(int'(cd_y), int'(cd_move)));
    end

    // Transaction-level model: phase 0 waiting, 1 looking up, 2 committing.
    int mx [2] = '{1, 30};
    int my [2] = '{1, 30};
    int mcool [2] = '{0, 0};
    int phase = 0;
    int mwin = 0;
    int mmv = 0;
    int mmap = 0;
    int mcx = 0;
    int mcy = 0;
    int mlast = 1;

    function automatic int norm(int c);
        return (c > 4) ? 0 : c;
    endfunction

    function automatic int elig(int p);
        int c;
        c = (p == 0) ? int'(move0_i) : int'(move1_i);
        return (req_i[p] && norm(c) != 0 && mcool[p] == 0) ? 1 : 0;
    endfunction

    function automatic int pick();
        if (elig(0) != 0 && elig(1) != 0) return (mlast == 1) ? 0 : 1;
        return (elig(0) != 0) ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            mx[0] <= 1;  my[0] <= 1;  mx[1] <= 30;  my[1] <= 30;
            mcool[0] <= 0;  mcool[1] <= 0;
            phase <= 0;  mlast <= 1;
        end else if (restart) begin
            mx[0] <= 1;  my[0] <= 1;  mx[1] <= 30;  my[1] <= 30;
            mcool[0] <= 0;  mcool[1] <= 0;
            phase <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mcool[i] > 0) mcool[i] <= mcool[i] - 1;
            end
            if (phase == 0) begin
                if (elig(0) != 0 || elig(1) != 0) begin
                    mwin  <= pick();
                    mlast <= pick();
                    mmv   <= norm((pick() == 1) ? int'(move1_i) : int'(move0_i));
                    mmap  <= int'(map_i);
                    phase <= 1;
                end
            end else if (phase == 1) begin
                mcx   <= step_x(mx[mwin], mmv);
                mcy   <= step_y(my[mwin], mmv);
                phase <= 2;
            end else begin
                if (!(mcx == mx[1-mwin] && mcy == my[1-mwin])) begin
                    mx[mwin] <= mcx;
                    my[mwin] <= mcy;
                end
                mcool[mwin] <= COOL;
                phase <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        int ea, ecx, ecy, ecm, ecmap;
        ea = (phase == 2 && resetn && !restart) ? (1 << mwin) : 0;
        if (phase == 1) begin
            ecx = mx[mwin];  ecy = my[mwin];  ecm = mmv;  ecmap = mmap;
        end else begin
            ecx = mx[0];  ecy = my[0];  ecm = 0;  ecmap = int'(map_i);
        end
        chk("ack", int'(ack_o), ea);
        chk("busy", int'(busy_o), (phase != 0) ? 1 : 0);
        chk("p0_x", int'(p0_x), mx[0]);
        chk("p0_y", int'(p0_y), my[0]);
        chk("p1_x", int'(p1_x), mx[1]);
        chk("p1_y", int'(p1_y), my[1]);
        chk("cd_x", int'(cd_x), ecx);
        chk("cd_y", int'(cd_y), ecy);
        chk("cd_move", int'(cd_move), ecm);
        chk("cd_map", int'(cd_map), ecmap);
    endtask

    // One clock: compare at the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        last_ack = ack_o;
        if (cmp_en) model_compare();
        @(posedge clk);
        #1;
    endtask

    task automatic move_player(input int p, input int code);
        int got;
        got = 0;
        if (p == 0) move0_i = 3'(code); else move1_i = 3'(code);
        req_i[p] = 1'b1;
        for (int k = 0; k < 20 && got == 0; k++) begin
            tick();
            if (last_ack[p]) got = 1;
        end
        req_i[p] = 1'b0;
        chk("move_ack_seen", got, 1);
        repeat (COOL) tick();
    endtask

    initial begin
        int a0, a1, first, second;

        // Reset state.
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rst_p0_x", int'(p0_x), 1);
        chk("rst_p0_y", int'(p0_y), 1);
        chk("rst_p1_x", int'(p1_x), 30);
        chk("rst_p1_y", int'(p1_y), 30);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_cd_move", int'(cd_move), 0);
        chk("model_rst_p1_x", mx[1], 30);

        // Single move right from (1,1).
        req_i = 2'b01;
        move0_i = 3'd4;
        tick();
        #1;
        chk("lookup_busy", int'(busy_o), 1);
        chk("lookup_cd_x", int'(cd_x), 1);
        chk("lookup_cd_move", int'(cd_move), 4);
        tick();
        #1;
        chk("commit_ack", int'(ack_o), 1);
        chk("commit_p0_x_old", int'(p0_x), 1);
        tick();
        req_i = 2'b00;
        #1;
        chk("after_p0_x", int'(p0_x), 2);
        chk("after_p0_y", int'(p0_y), 1);
        chk("after_p1_x", int'(p1_x), 30);
        chk("after_ack", int'(ack_o), 0);
        chk("model_p0_x", mx[0], 2);

        // Simultaneous requests after reset: P0 first, P1 three cycles later.
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        req_i = 2'b11;
        move0_i = 3'd4;
        move1_i = 3'd3;
        a0 = -1;
        a1 = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (last_ack[0] && a0 < 0) begin a0 = k; req_i[0] = 1'b0; end
            if (last_ack[1] && a1 < 0) begin a1 = k; req_i[1] = 1'b0; end
        end
        chk("tie_p0_ack_cycle", a0, 3);
        chk("tie_p1_ack_cycle", a1, 6);
        chk("tie_p0_x", int'(p0_x), 2);
        chk("tie_p1_x", int'(p1_x), 29);
        chk("tie_p1_y", int'(p1_y), 30);

        // Walk P0 next to P1 at (29,30), then try to step onto it.
        for (int k = 0; k < 26; k++) move_player(0, 4);
        for (int k = 0; k < 29; k++) move_player(0, 2);
        chk("walk_p0_x", int'(p0_x), 28);
        chk("walk_p0_y", int'(p0_y), 30);
        move_player(0, 4);
        chk("blocked_p0_x", int'(p0_x), 28);
        chk("blocked_p0_y", int'(p0_y), 30);

        // Held request: second ack only after the cooldown drains.
        req_i[0] = 1'b1;
        move0_i = 3'd1;
        first = -1;
        second = -1;
        for (int k = 1; k <= 30 && second < 0; k++) begin
            tick();
            if (last_ack[0]) begin
                if (first < 0) first = k; else second = k;
            end
        end
        req_i[0] = 1'b0;
        chk("held_ack_gap", second - first, 7);
        repeat (COOL + 1) tick();
        chk("held_p0_y", int'(p0_y), 28);

        // Restart during LOOKUP aborts without an ack.
        req_i = 2'b01;
        move0_i = 3'd4;
        tick();
        restart = 1'b1;
        req_i = 2'b00;
        #1;
        chk("restart_busy_in_lookup", int'(busy_o), 1);
        tick();
        restart = 1'b0;
        #1;
        chk("restart_busy", int'(busy_o), 0);
        chk("restart_p0_x", int'(p0_x), 1);
        chk("restart_p0_y", int'(p0_y), 1);
        chk("restart_p1_x", int'(p1_x), 30);
        tick();
        chk("restart_no_ack", int'(last_ack), 0);

        // Null and out-of-range codes are never granted.
        req_i = 2'b01;
        move0_i = 3'd0;
        repeat (4) begin
            tick();
            chk("null_busy", int'(busy_o), 0);
        end
        move0_i = 3'd7;
        repeat (4) begin
            tick();
            chk("code7_busy", int'(busy_o), 0);
            chk("code7_ack", int'(last_ack), 0);
        end
        req_i = 2'b00;
        tick();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            resetn  = ($urandom_range(0, 499) != 0);
            restart = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) map_i = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                if (!req_i[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_i[p] = 1'b1;
                        if (p == 0) move0_i = 3'($urandom_range(0, 7));
                        else        move1_i = 3'($urandom_range(0, 7));
                    end
                end else if (last_ack[p]) begin
                    if ($urandom_range(0, 1) == 0) req_i[p] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req_i[p] = 1'b0;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
